instr_fetch_queue: RTL and testbench

Instruction fetch front-end between the core's next-PC logic and the instruction memory. It owns the fetch PC and issues sequential word requests over a req/gnt/rvalid handshake. Returned instructions are buffered, each with its PC, in a small in-order FIFO, and handed to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard responses still in flight.

---
 rtl/instr_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction fetch front-end.
//
// Owns the fetch PC and issues sequential word requests to instruction memory over a
// req/gnt/rvalid handshake. Returned words are buffered with their PC in a small in-order
// FIFO and handed to decode over valid/ready. A redirect flushes the FIFO, restarts fetch
// at the new PC and discards any responses still in flight.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16); also caps outstanding requests
//   RESET_PC  fetch address after reset
// Ports:
//   clock        sole clock, all state updates on posedge
//   reset_       synchronous active-low reset
//   imem_req     request valid (combinational from state and redirect)
//   imem_addr    word address of the request
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid; responses return in grant order
//   imem_rdata   response instruction word
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   out_valid    FIFO head valid
//   out_instr    FIFO head instruction (zero when out_valid is low)
//   out_pc       PC of out_instr (zero when out_valid is low)
//   out_ready    consumer accepts the head

module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clock,
   input  logic        reset_,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Counters must hold 0..DEPTH inclusive.
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic [CW:0]   occupancy;
   logic          grant;
   logic          drop;
   logic          push;
   logic          pop;

   // Slots already committed: buffered entries plus requests whose data will be kept.
   // Responses marked for dropping never take a FIFO slot, so they do not throttle fetch.
   assign occupancy = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};

   assign imem_req  = reset_ && !redirect && (occupancy < (CW + 1)'(DEPTH));
   assign imem_addr = fetch_pc_q;

   assign grant = imem_req && imem_gnt;
   assign drop  = imem_rvalid && (drop_cnt_q != '0);
   assign push  = imem_rvalid && !drop && !redirect;

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready && !redirect;

   // Head is masked so stale storage is never visible while the queue is empty.
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q;
      drop_cnt_d = drop_cnt_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         resp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
         // Everything still outstanding after this cycle belongs to the old path.
         inflight_d = inflight_q - CW'(imem_rvalid);
         drop_cnt_d = inflight_q - CW'(imem_rvalid);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
         if (drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage needs no reset: reads are masked by out_valid.
   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_ = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;

   int          n_checks = 0;
   int          n_pass = 0;
   int          pop_count = 0;
   int          grant_count = 0;
   bit          rsp_en = 1'b1;
   logic [31:0] exp_q[$];
   logic [31:0] pend_q[$];

   instr_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clock       (clock),
      .reset_      (reset_),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready)
   );

   always #5 clock = ~clock;

   // Memory contents: each word is a fixed scramble of its own address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Instruction memory model (1-cycle latency, stallable) and output monitor.
   // Runs 2 time units after each negedge, after stimulus has settled.
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (!reset_) begin
            pend_q.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end else begin
            if (rsp_en && pend_q.size() > 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr_of(pend_q.pop_front());
            end else begin
               imem_rvalid = 1'b0;
               imem_rdata  = '0;
            end
            if (imem_req && imem_gnt) begin
               pend_q.push_back(imem_addr);
               grant_count++;
            end
            // A kept response must always find a free FIFO slot.
            if (imem_rvalid && !redirect && dut.drop_cnt_q == '0) begin
               n_checks++;
               assert (int'(dut.count_q) < DEPTH) n_pass++;
               else $display("FAIL fifo_overflow: count %0d, limit %0d", dut.count_q, DEPTH);
            end
            if (out_valid && out_ready && !redirect) begin
               pop_count++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_output: got pc %h, expected none", out_pc);
               end else begin
                  logic [31:0] pc;
                  pc = exp_q.pop_front();
                  check("out_pc", out_pc, pc);
                  check("out_instr", out_instr, instr_of(pc));
               end
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Holds reset for two edges, checks reset outputs, then releases at a negedge (cycle 0).
   task automatic do_reset();
      @(negedge clock);
      reset_ = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; out_ready = 1'b0; rsp_en = 1'b1;
      step(2);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      pop_count = 0;
      grant_count = 0;
      @(negedge clock);
      reset_ = 1'b1;
   endtask

   initial begin
      // Streaming after reset: one instruction per cycle from cycle 2.
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      #1;
      check("t1_first_req", 32'(imem_req), 32'd1);
      check("t1_first_addr", imem_addr, 32'h0);
      step(1); #1;
      check("t1_no_bypass", 32'(out_valid), 32'd0);
      step(1); #1;
      check("t1_first_valid", 32'(out_valid), 32'd1);
      check("t1_first_pc", out_pc, 32'h0);
      step(6);
      imem_gnt = 1'b0;
      step(2); #1;
      check("t1_pops", 32'(pop_count), 32'd8);
      check("t1_grants", 32'(grant_count), 32'd8);
      check("t1_drained", 32'(out_valid), 32'd0);

      // Backpressure: exactly DEPTH grants, head held stable.
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      step(6); #1;
      check("t2_grants", 32'(grant_count), 32'd4);
      check("t2_req_off", 32'(imem_req), 32'd0);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_head_pc", out_pc, 32'h0);
      check("t2_head_instr", out_instr, instr_of(32'h0));
      step(1); #1;
      check("t2_hold_pc", out_pc, 32'h0);
      check("t2_hold_grants", 32'(grant_count), 32'd4);
      step(1);
      out_ready = 1'b1; imem_gnt = 1'b0;
      step(5); #1;
      check("t2_pops", 32'(pop_count), 32'd4);

      // Redirect to 0x41 with two requests in flight.
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b1; rsp_en = 1'b0;
      step(2);
      redirect = 1'b1; redirect_pc = 32'h41;
      exp_q.push_back(32'h40); exp_q.push_back(32'h44);
      #1;
      check("t3_req_low", 32'(imem_req), 32'd0);
      step(1);
      redirect = 1'b0; rsp_en = 1'b1;
      #1;
      check("t3_valid_low", 32'(out_valid), 32'd0);
      check("t3_req", 32'(imem_req), 32'd1);
      check("t3_addr", imem_addr, 32'h40);
      step(2);
      imem_gnt = 1'b0;
      #1;
      check("t3_still_empty", 32'(out_valid), 32'd0);
      step(1); #1;
      check("t3_first_pc", out_pc, 32'h40);
      step(3); #1;
      check("t3_pops", 32'(pop_count), 32'd2);

      // Redirect coinciding with rvalid and a would-be pop.
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b1; rsp_en = 1'b0;
      step(2);
      rsp_en = 1'b1;
      step(1);
      redirect = 1'b1; redirect_pc = 32'h100;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      #1;
      check("t4_head_pc", out_pc, 32'h0);
      step(1);
      redirect = 1'b0;
      #1;
      check("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
      check("t4_inflight", 32'(dut.inflight_q), 32'd1);
      check("t4_valid_low", 32'(out_valid), 32'd0);
      check("t4_no_pop", 32'(pop_count), 32'd0);
      step(2);
      imem_gnt = 1'b0;
      step(3); #1;
      check("t4_pops", 32'(pop_count), 32'd2);

      // Redirect to the top word: PC wraps to zero; first output at R+3.
      do_reset();
      imem_gnt = 1'b0; out_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
      step(1);
      redirect = 1'b0; imem_gnt = 1'b1;
      #1;
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      step(1); #1;
      check("t5_addr_wrap", imem_addr, 32'h0);
      step(1);
      imem_gnt = 1'b0;
      #1;
      check("t5_valid_r3", 32'(out_valid), 32'd1);
      check("t5_first_pc", out_pc, 32'hFFFF_FFFC);
      step(3); #1;
      check("t5_pops", 32'(pop_count), 32'd2);

      // Reset mid-burst with three requests in flight.
      do_reset();
      imem_gnt = 1'b1; out_ready = 1'b1; rsp_en = 1'b0;
      step(3);
      check("t6_inflight_pre", 32'(dut.inflight_q), 32'd3);
      reset_ = 1'b0;
      step(1);
      check("t6_valid_low", 32'(out_valid), 32'd0);
      check("t6_inflight_clr", 32'(dut.inflight_q), 32'd0);
      check("t6_req_in_rst", 32'(imem_req), 32'd0);
      reset_ = 1'b1; rsp_en = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      #1;
      check("t6_restart_req", 32'(imem_req), 32'd1);
      check("t6_restart_addr", imem_addr, 32'h0);
      step(2);
      imem_gnt = 1'b0;
      step(3); #1;
      check("t6_pops", 32'(pop_count), 32'd2);
      check("final_expected", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
